dma_timing_control_nch: RTL
===========================

# dma_timing_control_nch

Parametrised N-channel DMA timing-and-control engine: arbitrates unmasked channel requests, negotiates the bus with the host via HRQ/HLDA, and sequences one-hot states SI/SO/S1/S2/S3/S4 to drive address, acknowledge and read/write strobes. It adds the following to the fixed 4-channel sequencer:

- Configurable channel count.
- Rotating priority.
- Demand mode.
- Compressed timing.
- READY wait states.
- Per-channel address and word counters with terminal count (EOP_N).

It sits between the channel register file and the system bus, and exports its state for the SVA checker.

## Interface
- NCH, 4: number of channels (1..8).
- ADDR_W, 16: address counter width.
- CNT_W, 16: word counter width.
- CLK  in  1  system clock, all flops on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CS_N  in  1  chip select; cfg loads accepted only when 0.
- DREQ  in  NCH  per-channel request, active high.
- HLDA  in  1  host hold acknowledge.
- READY  in  1  0 inserts a wait state.
- cfgLoad  in  1  pulse: load channel cfgChan.
- cfgChan  in  $clog2(NCH) (min 1)  channel to load.
- cfgAddr  in  ADDR_W  base address.
- cfgCount  in  CNT_W  word count, where transfers = count+1.
- cfgType  in  2  01 write (IOR_N+MEMW_N), 10 read (MEMR_N+IOW_N), 00/11 verify (no strobes).
- cfgRotate  in  1  1 = rotating priority, 0 = fixed (ch0 highest).
- cfgDemand  in  1  1 = demand mode, 0 = single mode.
- cfgCompressed  in  1  1 = skip S3.
- HRQ  out  1  hold request.
- AEN  out  1  address enable.
- ADSTB  out  1  address strobe.
- DACK  out  NCH  one-hot acknowledge.
- ADDR  out  ADDR_W  current address of active channel.
- IOR_N, IOW_N, MEMR_N, MEMW_N  out  1 each  active-low strobes.
- EOP_N  out  1  terminal-count pulse, active low.
- MASK  out  NCH  per-channel mask.
- STATE  out  6  one-hot encodings:
  - SI = 000001
  - SO = 000010
  - S1 = 000100
  - S2 = 001000
  - S3 = 010000
  - S4 = 100000

## Operation
- **Reset (async, RESET_N = 0):**
  - STATE = SI.
  - HRQ, AEN, ADSTB = 0; DACK = 0; ADDR = 0.
  - All strobes = 1; EOP_N = 1.
  - MASK = all ones; counters = 0; priority pointer = ch0.
  - Applies mid-transfer too; no transfer completes.
- **Configuration:** cfgLoad with CS_N = 0 in SI loads the channel's current and base address/count/type and clears its MASK bit. It is ignored in any other state.
- **Arbitration in SI:** if any DREQ & ~MASK, latch the winner and go to SO.
  - Fixed: lowest index wins.
  - Rotating: search starts at the channel after the last one serviced.
- **SO:** HRQ = 1.
  - HLDA = 1 → S1.
  - Latched channel's DREQ drops before HLDA → SI, HRQ = 0.
- **S1:** AEN = 1, ADSTB = 1, ADDR = current address.
- **S2:**
  - DACK[ch] = 1.
  - Read-side strobe (IOR_N or MEMR_N) asserted.
  - Compressed: write-side strobe also asserted. S2 → S4 when READY = 1.
  - Normal: S2 → S3.
- **S3 (normal only):** read and write strobes asserted; S3 → S4 when READY = 1.
- **Wait states:** READY = 0 holds S3 (or S2 when compressed) with all outputs unchanged.
- **S4:**
  - Strobes deasserted; DACK, AEN stay 1.
  - Address increments mod 2^ADDR_W.
  - Count decrements; terminal count is the 0 → all-ones rollover.
  - On terminal count: EOP_N = 0 for S4, MASK[ch] set, next SI.
  - Else, demand mode with DREQ[ch] still 1: next S1, no re-arbitration, HRQ held.
  - Else: next SI.
- **On leaving S4 to SI:** HRQ, AEN, DACK = 0; rotating pointer updated to ch.
- **Verify type:** full state sequence, no strobes, counters still update.

## Timing
- All outputs are registered/decoded from STATE, so they are valid the cycle STATE is entered.
- DREQ sampled high in SI → STATE = SO next edge; HRQ high the same cycle.
- HLDA sampled high in SO → S1 next edge.
- Minimum single transfer:
  - Normal: 6 cycles SI..S4 (4 bus cycles S1..S4).
  - Compressed: 5 cycles.
- Demand burst: 4 cycles/word normal, 3 cycles/word compressed.
- DREQ changes after the grant are ignored except in SO and at the S4 decision.
- Simultaneous cfgLoad and DREQ in SI: load takes effect; arbitration uses the pre-load MASK.

## Test plan
- Reset mid-S3 → next cycle: STATE = 000001, strobes = 1, HRQ = 0, MASK = 4'b1111.
- Load ch2 (addr 16'h1000, count 1, type 01), DREQ = 4'b0100, HLDA tied 1, normal single → two transfers:
  - STATE sequence SI,SO,S1,S2,S3,S4 each.
  - ADDR 1000 then 1001.
  - IOR_N/MEMW_N low in S2/S3.
  - EOP_N low in second S4; MASK[2] = 1.
- Fixed vs rotating, DREQ = 4'b1001 held, count 3 each:
  - Fixed: DACK sequence 0001,0001,...
  - Rotating: 0001,1000,0001,1000.
- Compressed demand ch0 (count 2, type 10) with READY low for 2 cycles in first S2 → S2 held 3 cycles, then 3-cycle words; EOP_N on third S4.
- DREQ dropped in SO before HLDA → return to SI; HRQ = 0; no DACK.
- cfgLoad asserted in S2 → ignored; counters unchanged after transfer.

Source files
------------

// File: rtl/dma_timing_control_nch.sv
// N-channel DMA timing/control: arbitrates DREQ, handshakes HRQ/HLDA, sequences SI/SO/S1..S4 per word.
// Outputs decode from STATE (valid the cycle a state is entered); READY=0 stretches S3 (S2 when compressed).
module dma_timing_control_nch #(
    parameter int  NCH    = 4,
    parameter int  ADDR_W = 16,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CS_N,
    input  logic [NCH-1:0]    DREQ,
    input  logic              HLDA,
    input  logic              READY,
    input  logic              cfgLoad,
    input  logic [CH_W-1:0]   cfgChan,
    input  logic [ADDR_W-1:0] cfgAddr,
    input  logic [CNT_W-1:0]  cfgCount,
    input  logic [1:0]        cfgType,
    input  logic              cfgRotate,
    input  logic              cfgDemand,
    input  logic              cfgCompressed,
    output logic              HRQ,
    output logic              AEN,
    output logic              ADSTB,
    output logic [NCH-1:0]    DACK,
    output logic [ADDR_W-1:0] ADDR,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              EOP_N,
    output logic [NCH-1:0]    MASK,
    output logic [5:0]        STATE
);

    localparam logic [5:0] SI = 6'b000001;
    localparam logic [5:0] SO = 6'b000010;
    localparam logic [5:0] S1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001000;
    localparam logic [5:0] S3 = 6'b010000;
    localparam logic [5:0] S4 = 6'b100000;

    localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

    logic [5:0]        r_state;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_prio;
    logic [NCH-1:0]    r_mask;
    logic [ADDR_W-1:0] r_addr [NCH];
    logic [CNT_W-1:0]  r_cnt  [NCH];
    logic [1:0]        r_type [NCH];

    logic [NCH-1:0]    w_req;
    logic [2*NCH-1:0]  w_req2;
    logic              w_any;
    logic [CH_W-1:0]   w_start;
    logic [CH_W-1:0]   w_win;
    logic [CH_W:0]     w_k;
    logic [CH_W:0]     w_sum;
    logic [CH_W:0]     w_nxt;
    logic [CH_W-1:0]   w_prio_nxt;
    logic              w_chan_ok;
    logic              w_tc;
    logic [1:0]        w_typ;
    logic              w_rd_act;
    logic              w_wr_act;
    logic              w_dack_en;

    assign w_req   = DREQ & ~r_mask;
    assign w_any   = |w_req;
    assign w_start = cfgRotate ? r_prio : '0;

    // Doubled request vector rotated by the start point; lowest set bit is the winner's offset.
    assign w_req2 = {w_req, w_req} >> w_start;

    always_comb begin
        w_k = '0;
        for (int j = 2*NCH-1; j >= 0; j--) begin
            if (w_req2[j]) w_k = (CH_W+1)'(j);
        end
        w_sum = {1'b0, w_start} + w_k;
        if (w_sum >= NCH_L) w_sum = w_sum - NCH_L;
    end

    assign w_win = w_sum[CH_W-1:0];

    // Rotating search resumes at the channel after the one just serviced.
    always_comb begin
        w_nxt = {1'b0, r_ch} + (CH_W+1)'(1);
        if (w_nxt >= NCH_L) w_nxt = '0;
    end

    assign w_prio_nxt = w_nxt[CH_W-1:0];
    assign w_chan_ok  = ({1'b0, cfgChan} < NCH_L);
    assign w_tc       = (r_cnt[r_ch] == '0);
    assign w_typ      = r_type[r_ch];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= SI;
            r_ch    <= '0;
            r_prio  <= '0;
            r_mask  <= '1;
            for (int i = 0; i < NCH; i++) begin
                r_addr[i] <= '0;
                r_cnt[i]  <= '0;
                r_type[i] <= '0;
            end
        end else begin
            case (r_state)
                SI: begin
                    if (cfgLoad && !CS_N && w_chan_ok) begin
                        r_addr[cfgChan] <= cfgAddr;
                        r_cnt[cfgChan]  <= cfgCount;
                        r_type[cfgChan] <= cfgType;
                        r_mask[cfgChan] <= 1'b0;
                    end
                    if (w_any) begin
                        r_ch    <= w_win;
                        r_state <= SO;
                    end
                end
                SO: begin
                    if (HLDA)            r_state <= S1;
                    else if (!DREQ[r_ch]) r_state <= SI;
                end
                S1: r_state <= S2;
                S2: begin
                    if (!cfgCompressed) r_state <= S3;
                    else if (READY)     r_state <= S4;
                end
                S3: begin
                    if (READY) r_state <= S4;
                end
                S4: begin
                    r_addr[r_ch] <= r_addr[r_ch] + ADDR_W'(1);
                    r_cnt[r_ch]  <= r_cnt[r_ch] - CNT_W'(1);
                    if (w_tc) begin
                        r_mask[r_ch] <= 1'b1;
                        r_prio       <= w_prio_nxt;
                        r_state      <= SI;
                    end else if (cfgDemand && DREQ[r_ch]) begin
                        r_state <= S1;
                    end else begin
                        r_prio  <= w_prio_nxt;
                        r_state <= SI;
                    end
                end
                default: r_state <= SI;
            endcase
        end
    end

    assign STATE     = r_state;
    assign MASK      = r_mask;
    assign HRQ       = |r_state[5:1];
    assign AEN       = |r_state[5:2];
    assign ADSTB     = r_state[2];
    assign w_dack_en = |r_state[5:3];
    assign ADDR      = AEN ? r_addr[r_ch] : '0;

    always_comb begin
        DACK = '0;
        for (int j = 0; j < NCH; j++) begin
            if (r_ch == CH_W'(j)) DACK[j] = w_dack_en;
        end
    end

    // Read side is live in S2 and S3; write side joins in S2 only when S3 is skipped.
    assign w_rd_act = r_state[3] | r_state[4];
    assign w_wr_act = r_state[4] | (r_state[3] & cfgCompressed);

    assign IOR_N  = ~(w_rd_act && (w_typ == 2'b01));
    assign MEMW_N = ~(w_wr_act && (w_typ == 2'b01));
    assign MEMR_N = ~(w_rd_act && (w_typ == 2'b10));
    assign IOW_N  = ~(w_wr_act && (w_typ == 2'b10));
    assign EOP_N  = ~(r_state[5] & w_tc);

endmodule
